// File: rtl/ahb_timer_pkg.sv
// Shared constants for the AHB-Lite timer bank: register offsets, CTRL bit
// positions, bus size encoding and channel stride.
package ahb_timer_pkg;

    typedef enum logic [1:0] {
        OFS_CTRL   = 2'd0,
        OFS_COUNT  = 2'd1,
        OFS_CMP    = 2'd2,
        OFS_STATUS = 2'd3
    } reg_ofs_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_PS      = 8;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned CH_STRIDE = 16;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/COUNT/CMP/STATUS registers, prescaler,
// compare-match logic and registered interrupt.
module timer_channel
    import ahb_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PS_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_rd,
    output logic [31:0] count_rd,
    output logic [31:0] cmp_rd,
    output logic [31:0] status_rd,
    output logic        irq
);

    logic             en;
    logic             oneshot;
    logic             irq_en;
    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  psc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cmp;
    logic             match;

    logic psc_tick;
    logic tick;
    logic hit;
    logic unused_wdata;

    // A COUNT write swallows the tick entirely, including any match it would cause.
    always_comb begin
        psc_tick     = en && (psc == ps);
        tick         = psc_tick && !wr_count;
        hit          = tick && (count == cmp);
        unused_wdata = ^wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            irq_en  <= 1'b0;
            ps      <= '0;
            psc     <= '0;
            count   <= '0;
            cmp     <= '0;
            match   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_ctrl || !en || psc_tick) psc <= '0;
            else                            psc <= psc + PS_W'(1);

            if (wr_ctrl) begin
                en      <= wdata[CTRL_EN];
                oneshot <= wdata[CTRL_ONESHOT];
                irq_en  <= wdata[CTRL_IRQ_EN];
                ps      <= wdata[CTRL_PS +: PS_W];
            end else if (hit && oneshot) begin
                en <= 1'b0;
            end

            if (wr_count)  count <= wdata[CNT_W-1:0];
            else if (hit)  count <= '0;
            else if (tick) count <= count + CNT_W'(1);

            if (wr_cmp) cmp <= wdata[CNT_W-1:0];

            if (hit)                        match <= 1'b1;
            else if (wr_status && wdata[0]) match <= 1'b0;

            irq <= match & irq_en;
        end
    end

    always_comb begin
        ctrl_rd                      = '0;
        ctrl_rd[CTRL_EN]             = en;
        ctrl_rd[CTRL_ONESHOT]        = oneshot;
        ctrl_rd[CTRL_IRQ_EN]         = irq_en;
        ctrl_rd[CTRL_PS +: PS_W]     = ps;
        count_rd                     = 32'(count);
        cmp_rd                       = 32'(cmp);
        status_rd                    = {31'b0, match};
    end

endmodule

// File: rtl/ahb_timer_bank.sv
// Multi-channel AHB-Lite timer/counter: zero-wait-state slave with address
// phase capture, register decode, read mux and one timer_channel per channel.
module ahb_timer_bank
    import ahb_timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    logic       dp_valid;
    logic       dp_write;
    logic       dp_size_ok;
    logic [7:0] dp_addr;

    logic [3:0] dp_ch;
    reg_ofs_e   dp_ofs;
    logic       dp_hit;
    logic       wr_en;
    logic       rd_en;
    logic       unused_haddr;

    logic [31:0] rd_ctrl   [NUM_CH];
    logic [31:0] rd_count  [NUM_CH];
    logic [31:0] rd_cmp    [NUM_CH];
    logic [31:0] rd_status [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_size_ok <= 1'b0;
            dp_addr    <= '0;
        end else begin
            dp_valid <= HSEL && HREADY;
            if (HSEL && HREADY) begin
                dp_write   <= HWRITE;
                dp_size_ok <= (HSIZE == HSIZE_WORD);
                dp_addr    <= HADDR[7:0];
            end
        end
    end

    always_comb begin
        dp_ch        = dp_addr[7:4];
        dp_ofs       = reg_ofs_e'(dp_addr[3:2]);
        dp_hit       = dp_valid && (dp_addr[7:6] == 2'b00) && (32'(dp_ch) < NUM_CH);
        wr_en        = dp_hit && dp_write && dp_size_ok;
        rd_en        = dp_hit && !dp_write;
        unused_haddr = ^{HADDR[31:8], HADDR[1:0]};
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_sel;

        always_comb ch_sel = wr_en && (dp_ch == 4'(g));

        timer_channel #(
            .CNT_W (CNT_W),
            .PS_W  (PS_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_ctrl   (ch_sel && (dp_ofs == OFS_CTRL)),
            .wr_count  (ch_sel && (dp_ofs == OFS_COUNT)),
            .wr_cmp    (ch_sel && (dp_ofs == OFS_CMP)),
            .wr_status (ch_sel && (dp_ofs == OFS_STATUS)),
            .wdata     (HWDATA),
            .ctrl_rd   (rd_ctrl[g]),
            .count_rd  (rd_count[g]),
            .cmp_rd    (rd_cmp[g]),
            .status_rd (rd_status[g]),
            .irq       (irq[g])
        );
    end

    always_comb begin
        HRDATA = '0;
        if (rd_en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (dp_ch == 4'(i)) begin
                    unique case (dp_ofs)
                        OFS_CTRL:   HRDATA = rd_ctrl[i];
                        OFS_COUNT:  HRDATA = rd_count[i];
                        OFS_CMP:    HRDATA = rd_cmp[i];
                        OFS_STATUS: HRDATA = rd_status[i];
                        default:    HRDATA = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        irq_any   = |irq;
    end

endmodule

// File: tb/tb_ahb_timer_bank.sv
// Self-checking bench for ahb_timer_bank: a 4-channel 32-bit instance and a
// 1-channel 8-bit instance for the wrap-around cases.
module tb_ahb_timer_bank;
    import ahb_timer_pkg::*;

    logic        clk;
    logic        rst;
    logic        HSEL_a, HSEL_b;
    logic        HREADY;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA_a, HRDATA_b;
    logic        HREADYOUT_a, HREADYOUT_b;
    logic        HRESP_a, HRESP_b;
    logic [3:0]  irq_a;
    logic [0:0]  irq_b;
    logic        irq_any_a, irq_any_b;

    ahb_timer_bank #(.NUM_CH(4), .CNT_W(32), .PS_W(8)) dut_a (
        .clk(clk), .rst(rst), .HSEL(HSEL_a), .HREADY(HREADY), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA_a),
        .HREADYOUT(HREADYOUT_a), .HRESP(HRESP_a), .irq(irq_a), .irq_any(irq_any_a)
    );

    ahb_timer_bank #(.NUM_CH(1), .CNT_W(8), .PS_W(8)) dut_b (
        .clk(clk), .rst(rst), .HSEL(HSEL_b), .HREADY(HREADY), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA_b),
        .HREADYOUT(HREADYOUT_b), .HRESP(HRESP_b), .irq(irq_b), .irq_any(irq_any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [31:0] data;   // write data, or expected read value
        string       name;
    } vec_t;
    vec_t tbl[14];

    logic [31:0] samp_d   [32];
    logic [3:0]  samp_irq [32];
    logic        samp_any [32];

    task automatic sb_push(input string nm, input logic [31:0] e);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t s;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got %h with no expected value queued", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", s.name, act, s.exp);
            end
        end
    endtask

    function automatic logic [31:0] rdata(input bit b);
        return b ? HRDATA_b : HRDATA_a;
    endfunction

    task automatic idle();
        HSEL_a = 1'b0;
        HSEL_b = 1'b0;
        HWRITE = 1'b0;
        HSIZE  = HSIZE_WORD;
    endtask

    task automatic bus_write(input bit b, input logic [7:0] a, input logic [31:0] d,
                             input logic [2:0] sz);
        @(negedge clk);
        HSEL_a = !b; HSEL_b = b;
        HADDR = {24'h0, a}; HWRITE = 1'b1; HSIZE = sz;
        @(negedge clk);
        idle();
        HWDATA = d;
    endtask

    task automatic bus_read(input bit b, input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        HSEL_a = !b; HSEL_b = b;
        HADDR = {24'h0, a}; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        @(negedge clk);
        idle();
        d = rdata(b);
    endtask

    task automatic check_read(input bit b, input logic [7:0] a, input logic [31:0] e,
                              input string nm);
        logic [31:0] d;
        sb_push(nm, e);
        bus_read(b, a, d);
        sb_check(d);
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] e);
        sb_push(nm, e);
        sb_check(act);
    endtask

    // Write immediately followed by a read whose address phase overlaps the write data phase.
    task automatic wr_rd(input bit b, input logic [7:0] aw, input logic [31:0] dw,
                         input logic [7:0] ar, output logic [31:0] d);
        @(negedge clk);
        HSEL_a = !b; HSEL_b = b;
        HADDR = {24'h0, aw}; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(negedge clk);
        HADDR = {24'h0, ar}; HWRITE = 1'b0; HWDATA = dw;
        @(negedge clk);
        idle();
        d = rdata(b);
    endtask

    // Pipelined reads of one address: sample k is the register value k+2 cycles after the prior write's data phase.
    task automatic stream(input bit b, input logic [7:0] a, input int n);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                samp_d[k-1]   = rdata(b);
                samp_irq[k-1] = irq_a;
                samp_any[k-1] = irq_any_a;
            end
            if (k < n) begin
                HSEL_a = !b; HSEL_b = b;
                HADDR = {24'h0, a}; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
            end else begin
                idle();
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] e;

        tbl[0]  = '{1'b1, 8'h08, 3'b000,     32'h0000_0055, "byte_wr"};
        tbl[1]  = '{1'b0, 8'h08, HSIZE_WORD, 32'h0000_0000, "cmp_after_byte_wr"};
        tbl[2]  = '{1'b1, 8'h48, HSIZE_WORD, 32'h0000_0099, "oob_cmp_wr"};
        tbl[3]  = '{1'b1, 8'h40, HSIZE_WORD, 32'h0000_0001, "oob_ctrl_wr"};
        tbl[4]  = '{1'b0, 8'h48, HSIZE_WORD, 32'h0000_0000, "oob_rd"};
        tbl[5]  = '{1'b0, 8'h08, HSIZE_WORD, 32'h0000_0000, "ch0_cmp_untouched"};
        tbl[6]  = '{1'b0, 8'h00, HSIZE_WORD, 32'h0000_0000, "ch0_ctrl_untouched"};
        tbl[7]  = '{1'b1, 8'hC8, HSIZE_WORD, 32'h0000_0033, "hi_addr_wr"};
        tbl[8]  = '{1'b0, 8'h08, HSIZE_WORD, 32'h0000_0000, "ch0_cmp_after_hi"};
        tbl[9]  = '{1'b1, 8'h04, HSIZE_WORD, 32'h0012_3456, "ch0_count_wr"};
        tbl[10] = '{1'b0, 8'h04, HSIZE_WORD, 32'h0012_3456, "ch0_count_rd"};
        tbl[11] = '{1'b1, 8'h00, HSIZE_WORD, 32'hFFFF_FFF6, "ch0_ctrl_wr"};
        tbl[12] = '{1'b0, 8'h00, HSIZE_WORD, 32'h0000_FF06, "ch0_ctrl_mask"};
        tbl[13] = '{1'b1, 8'h00, HSIZE_WORD, 32'h0000_0000, "ch0_ctrl_clr"};

        rst = 1'b1; HREADY = 1'b1; HADDR = '0; HWDATA = '0;
        idle();
        repeat (3) @(negedge clk);
        check_val("rst_hreadyout", {31'b0, HREADYOUT_a}, 32'h1);
        check_val("rst_hresp", {31'b0, HRESP_a}, 32'h0);
        check_val("rst_hrdata", HRDATA_a, 32'h0);
        check_val("rst_irq", {28'b0, irq_a}, 32'h0);
        check_val("rst_irq_any", {31'b0, irq_any_a}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_read(0, 8'h1C, 32'h0, "rst_ch1_status");

        // Bus corner cases
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) bus_write(0, tbl[i].addr, tbl[i].data, tbl[i].size);
            else           check_read(0, tbl[i].addr, tbl[i].data, tbl[i].name);
        end
        sb_push("b2b_wr_rd", 32'h7);
        wr_rd(0, 8'h08, 32'h7, 8'h08, d);
        sb_check(d);
        bus_write(0, 8'h08, 32'h0, HSIZE_WORD);

        // Periodic mode on ch1
        bus_write(0, 8'h18, 32'h4, HSIZE_WORD);
        bus_write(0, 8'h14, 32'h0, HSIZE_WORD);
        bus_write(0, 8'h10, 32'h5, HSIZE_WORD);
        for (int i = 0; i < 7; i++) sb_push($sformatf("per_count%0d", i), 32'((i + 1) % 5));
        stream(0, 8'h14, 7);
        for (int i = 0; i < 7; i++) sb_check(samp_d[i]);
        for (int i = 0; i < 7; i++) begin
            e = (i >= 5) ? 32'h1 : 32'h0;
            check_val($sformatf("per_irq%0d", i), {31'b0, samp_irq[i][1]}, e);
            check_val($sformatf("per_any%0d", i), {31'b0, samp_any[i]}, e);
        end
        check_read(0, 8'h1C, 32'h1, "per_match");
        bus_write(0, 8'h10, 32'h4, HSIZE_WORD);
        bus_write(0, 8'h1C, 32'h1, HSIZE_WORD);
        @(negedge clk);
        check_val("irq_hold", {31'b0, irq_a[1]}, 32'h1);
        @(negedge clk);
        check_val("irq_fall", {31'b0, irq_a[1]}, 32'h0);
        check_val("irq_any_fall", {31'b0, irq_any_a}, 32'h0);

        // One-shot with prescaler on ch2
        bus_write(0, 8'h28, 32'h2, HSIZE_WORD);
        bus_write(0, 8'h20, 32'h303, HSIZE_WORD);
        for (int i = 0; i < 16; i++)
            sb_push($sformatf("os_count%0d", i), (i < 3) ? 32'h0 : (i < 7) ? 32'h1 : (i < 11) ? 32'h2 : 32'h0);
        stream(0, 8'h24, 16);
        for (int i = 0; i < 16; i++) sb_check(samp_d[i]);
        check_read(0, 8'h20, 32'h302, "os_ctrl");
        check_read(0, 8'h2C, 32'h1, "os_match");
        repeat (8) @(negedge clk);
        check_read(0, 8'h24, 32'h0, "os_count_stays");

        // Same-cycle conflicts on ch3 (CMP = 0 with PS = 0 matches on every tick)
        bus_write(0, 8'h30, 32'h1, HSIZE_WORD);
        sb_push("w1c_vs_match", 32'h1);
        wr_rd(0, 8'h3C, 32'h1, 8'h3C, d);
        sb_check(d);
        bus_write(0, 8'h38, 32'h100, HSIZE_WORD);
        sb_push("count_wr_vs_tick", 32'h10);
        wr_rd(0, 8'h34, 32'h10, 8'h34, d);
        sb_check(d);

        // Wrap-around on the 8-bit instance
        bus_write(1, 8'h08, 32'hFF, HSIZE_WORD);
        bus_write(1, 8'h04, 32'hFE, HSIZE_WORD);
        bus_write(1, 8'h00, 32'h1, HSIZE_WORD);
        for (int i = 0; i < 4; i++) sb_push($sformatf("wrap_match%0d", i), (i == 0) ? 32'hFF : 32'(i - 1));
        stream(1, 8'h04, 4);
        for (int i = 0; i < 4; i++) sb_check(samp_d[i]);
        check_read(1, 8'h0C, 32'h1, "wrap_match_flag");
        bus_write(1, 8'h00, 32'h0, HSIZE_WORD);
        bus_write(1, 8'h0C, 32'h1, HSIZE_WORD);
        bus_write(1, 8'h08, 32'h10, HSIZE_WORD);
        bus_write(1, 8'h04, 32'hFF, HSIZE_WORD);
        bus_write(1, 8'h00, 32'h1, HSIZE_WORD);
        for (int i = 0; i < 3; i++) sb_push($sformatf("wrap_nomatch%0d", i), 32'(i));
        stream(1, 8'h04, 3);
        for (int i = 0; i < 3; i++) sb_check(samp_d[i]);
        check_read(1, 8'h0C, 32'h0, "wrap_no_flag");
        check_val("b_irq_any", {31'b0, irq_any_b}, 32'h0);

        // Reset mid-run
        bus_write(0, 8'h00, 32'h1, HSIZE_WORD);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_pulse_hreadyout", {31'b0, HREADYOUT_a}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 4; o++)
                check_read(0, 8'(c * CH_STRIDE + o * 4), 32'h0, $sformatf("rst_ch%0d_reg%0d", c, o));
        check_read(1, 8'h04, 32'h0, "rst_b_count");
        check_val("rst_run_irq", {28'b0, irq_a}, 32'h0);
        check_val("rst_run_hreadyout", {31'b0, HREADYOUT_a}, 32'h1);
        check_val("rst_b_hready_resp", {30'b0, HREADYOUT_b, HRESP_b}, 32'h2);

        // Reset during a write data phase aborts the write
        @(negedge clk);
        HSEL_a = 1'b1; HADDR = 32'h08; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(negedge clk);
        idle();
        HWDATA = 32'h77;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_read(0, 8'h08, 32'h0, "rst_abort_wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
